serial2parallel: RTL
====================

Name: serial2parallel

Overview:
- Deserializer stage directly downstream of the team's parallel2serial block.
- Consumes the serial bit stream plus the one-cycle word-start marker and reassembles WIDTH-bit words.
- Presents each word on a valid/ready output interface with a one-word holding register.
- Flags overflow and framing errors as sticky status bits.

Parameters:
WIDTH, 4, bits per word; must be >= 2; must match the upstream serializer word width.
MSB_FIRST, 1, 1: first serial bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
din  input  1  serial data bit, sampled every clk.
din_frame  input  1  word-start marker, high in the same cycle as the first bit of a word.
dout  output  WIDTH  assembled word, registered.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
overflow  output  1  sticky: a completed word was dropped because the holding register was full.
frame_err  output  1  sticky: din_frame arrived while a word was partially assembled.
clr_err  input  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low.
  - Reset values: dout=0, dout_valid=0, overflow=0, frame_err=0, shift register=0, bit counter=0, state=HUNT.
  - Reset mid-word discards the partial word and any held output word.
- State machine, two states:
  - HUNT: din ignored unless din_frame=1. On din_frame=1, capture din as bit 0 of the word, set counter=1, go to SHIFT.
  - SHIFT, din_frame=0: capture din, increment counter. When the captured bit is the last one (counter==WIDTH-1), the word is complete, counter=0, and the state returns to HUNT.
  - SHIFT, din_frame=1 (any counter value, including the last-bit cycle): resync. Discard the partial word, set frame_err, capture din as bit 0 of the new word, set counter=1, stay in SHIFT.
- Bit order:
  - MSB_FIRST=1: shift left, inserting din at the LSB. After WIDTH bits, the first bit sits at dout[WIDTH-1].
  - MSB_FIRST=0: shift right, inserting at the MSB.
- Back-to-back words: din_frame in the cycle right after a completion is the normal streaming case, with a frame every WIDTH cycles. HUNT accepts it with no bubble.
- Word completion / output register:
  - Latency: the word appears on dout with dout_valid=1 in the cycle after the clk edge that samples its last bit.
  - The word is loaded if dout_valid=0, or if dout_valid && dout_ready in the completion cycle (simultaneous drain and load; dout_valid stays 1).
  - Otherwise the new word is dropped, overflow is set, and the held word is kept unchanged.
- Output hold: while dout_valid && !dout_ready, dout is stable. dout_valid falls on the edge after a handshake unless a new word loads on that same edge.
- Sticky flags: clr_err clears both flags. If a new error event occurs in the same cycle as clr_err, the error wins and the flag stays 1.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1.

Decomposition:
- Shared package p2s_pkg:
  - default WIDTH constant shared with parallel2serial;
  - state enum type (HUNT, SHIFT);
  - a function returning the counter width for WIDTH.
- One natural sub-module: s2p_out_reg, the one-entry valid/ready holding register with overflow detection. Shifter, counter and FSM stay in the top level.

Test Plan:
- Basic word, WIDTH=4, MSB_FIRST=1: din=1,0,1,1 with din_frame on the first bit, dout_ready=1 -> dout=4'hB, dout_valid=1 for exactly one cycle, one cycle after the 4th bit.
- Continuous stream: 3 back-to-back words 4'hB, 4'h6, 4'hF with a frame every 4 cycles, dout_ready=1 -> three valid pulses spaced 4 cycles apart, correct values, flags remain 0.
- Backpressure/overflow:
  - Setup: dout_ready=0 across two completed words 4'h3 then 4'hC.
  - Required: dout holds 4'h3; overflow=1 on the edge sampling the second word's last bit.
  - Then: raise dout_ready -> 4'h3 consumed, dout_valid drops, 4'hC never appears.
- Resync: din_frame reasserted on the 3rd bit of a word, followed by 4 bits 0,1,1,1 -> frame_err=1, dout=4'h7; the partial word is never output.
- Simultaneous drain and load: dout_valid=1 and dout_ready=1 in the cycle a new word (4'h9) completes -> dout_valid stays 1, dout=4'h9, overflow=0.
- Reset and clear:
  - Reset: assert rst_n low after 2 bits of a word -> all outputs 0 at once; after release, bits without din_frame produce no output.
  - Clear: clr_err together with a new overflow event -> overflow remains 1.
  - MSB_FIRST=0 variant: input 1,0,1,1 -> dout=4'hD.

Source files
------------

// File: rtl/p2s_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg: constants, state type and helpers shared by the serializer pair.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package p2s_pkg;

  localparam int P2S_WIDTH = 4;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_e;

  // Bit counter width; a 1-bit floor keeps degenerate widths legal.
  function automatic int s2p_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial2parallel_if.sv
// ---------------------------------------------------------------------------
// serial2parallel_if: serial input and valid/ready word output bundle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial2parallel_if import p2s_pkg::*; #(
  parameter int WIDTH = P2S_WIDTH
);
  logic             din;
  logic             din_frame;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (output din, output din_frame, output dout_ready,
                  input  dout, input  dout_valid);
  modport slave  (input  din, input  din_frame, input  dout_ready,
                  output dout, output dout_valid);
endinterface

`default_nettype wire

// File: rtl/serial2parallel_out_reg.sv
// ---------------------------------------------------------------------------
// s2p_out_reg: one-word valid/ready holding register with sticky overflow.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module s2p_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             overflow_q;
  logic             accept;
  logic             drop;

  // A slot is free when empty or when its word is handed off this cycle.
  assign accept = !valid_q || ready_i;
  assign drop   = word_valid_i && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (word_valid_i && accept) begin
        dout_q  <= word_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      overflow_q <= (overflow_q && !clr_err_i) || drop;
    end
  end

  assign dout_o     = dout_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/serial2parallel.sv
// ---------------------------------------------------------------------------
// serial2parallel: framed serial-to-parallel deserializer with error flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial2parallel import p2s_pkg::*; #(
  parameter int WIDTH     = P2S_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial2parallel_if.slave bus,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int            CW   = s2p_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  s2p_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] shreg_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] word_next;
  logic [WIDTH-2:0] shreg_next;
  logic [WIDTH-2:0] shreg_start;
  logic             resync;
  logic             word_done;

  // The shift register only holds the WIDTH-1 bits preceding the last one;
  // the final bit joins the word on its way into the holding register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign word_next   = {shreg_q, bus.din};
      assign shreg_next  = word_next[WIDTH-2:0];
      assign shreg_start = (WIDTH-1)'(bus.din);
    end else begin : g_lsb_first
      assign word_next   = {bus.din, shreg_q};
      assign shreg_next  = word_next[WIDTH-1:1];
      assign shreg_start = (WIDTH-1)'(bus.din) << (WIDTH - 2);
    end
  endgenerate

  assign resync    = (state_q == SHIFT) && bus.din_frame;
  assign word_done = (state_q == SHIFT) && !bus.din_frame && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (bus.din_frame) begin
            shreg_q <= shreg_start;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.din_frame) begin
            shreg_q <= shreg_start;
            cnt_q   <= CW'(1);
          end else begin
            shreg_q <= shreg_next;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= HUNT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= HUNT;
      endcase
      frame_err_q <= (frame_err_q && !clr_err) || resync;
    end
  end

  assign frame_err = frame_err_q;

  s2p_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_valid_i (word_done),
    .word_i       (word_next),
    .ready_i      (bus.dout_ready),
    .clr_err_i    (clr_err),
    .dout_o       (bus.dout),
    .valid_o      (bus.dout_valid),
    .overflow_o   (overflow)
  );

endmodule

`default_nettype wire
